fracnet_acc_requant: RTL
========================

Name: fracnet_acc_requant

Overview:
- Downstream consumer of the 16s x 12s -> 28s signed multiplier (4-stage latency, ce-gated).
- Accumulates a stream of signed 28-bit products into a wide accumulator until the last term of a dot product.
- At the last term, applies a round-half-up arithmetic right shift, saturates to 16-bit signed, and presents the result on a valid/ready output.
- Drives in_ready back to the multiplier's ce so backpressure stalls the multiply pipeline coherently.

Parameters:
- IN_W, 28, product input width (signed).
- ACC_W, 40, accumulator width; covers 4096 full-scale terms without wrap.
- OUT_W, 16, output width (signed).
- SHIFT_W, 5, width of runtime shift input.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  din carries a product this cycle (valid already delayed 4 cycles alongside the multiplier).
- in_last  in  1  final term of the current dot product; qualified by in_valid.
- din  in  IN_W  signed product from the multiplier.
- shift  in  SHIFT_W  right-shift amount 0..31; sampled on the in_last beat.
- in_ready  out  1  block accepts a beat this cycle; upstream ties it to the multiplier ce.
- out_valid  out  1  result held on dout.
- out_ready  in  1  downstream accepts dout.
- dout  out  OUT_W  saturated, rounded result.
- sat  out  1  result on dout was clipped; qualified by out_valid.
- term_cnt  out  16  terms accumulated in the current dot product; saturates at 0xFFFF.

Behaviour:
- Reset: reset low asynchronously clears acc, term_cnt, out_valid, dout, and sat to 0. in_ready = 1 after reset.
- Accept condition:
  - in_ready = !out_valid || out_ready (single output slot, combinational).
  - A beat is accepted when in_valid && in_ready.
  - When in_ready = 0, din/in_valid are ignored. The upstream pipeline is frozen by ce, so no beat is lost.
- Sign extension: din is sign-extended to ACC_W before all arithmetic.
- Non-last accepted beat: acc <= acc + din; term_cnt += 1.
- Last accepted beat:
  - sum = acc + din, computed in ACC_W+1 bits.
  - If shift = 0, r = sum. Otherwise r = (sum + 2^(shift-1)) >>> shift, arithmetic.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - dout <= saturated r; sat <= clip occurred; out_valid <= 1.
  - acc <= 0 and term_cnt <= 0 in the same cycle, so the next dot product starts clean with no bubble.
- Latency: 1 cycle from the in_last acceptance edge to out_valid high.
- Output handshake:
  - out_valid && out_ready retires the result; out_valid drops next cycle unless a new last beat is accepted that same cycle.
  - Retire and new last in the same cycle: out_valid stays 1 and dout/sat are replaced.
  - While out_valid && !out_ready, dout and sat are held stable.
- Single-term dot product (in_last on the first beat): sum = din.
- Accumulator overflow beyond ACC_W wraps two's-complement. This is out of contract for more than 4096 terms; term_cnt lets verification flag it.
- Reset mid-dot-product discards the partial sum. No output is produced for the aborted vector.
- in_last with in_valid = 0 is ignored.

Optional Feature:
- Macro: FRACNET_ACC_RELU_EN.
- Defined: after rounding and before saturation, negative r is forced to 0; sat is never set for negative values. Output range is [0, 2^(OUT_W-1)-1].
- Undefined: no rectification; full signed saturation as above.

Test Plan:
- Reset: hold reset low with din=1234, in_valid=1 -> out_valid=0, dout=0, term_cnt=0, in_ready=1; after release, the first beat is accepted normally.
- Basic accumulation: beats 100, -30, 50 (last), shift=0, out_ready=1 -> one cycle later out_valid=1, dout=120, sat=0; term_cnt back to 0.
- Rounding: single beat din=-5 (last), shift=1 -> dout=-2 (i.e. (-5+1)>>>1). Beat din=7, shift=2 -> dout=2.
- Saturation: beats 0x7FFFFFF, 0x7FFFFFF (last), shift=4 -> dout=32767, sat=1. Beat din=-2^27 (last), shift=0 -> dout=-32768, sat=1. With FRACNET_ACC_RELU_EN, the negative case gives dout=0, sat=0.
- Backpressure: result pending with out_ready=0 -> in_ready=0, next beat din=9 held upstream and not accumulated, dout stable. Raise out_ready -> first result retired and din=9 then accepted.
- Back-to-back vectors: last beat of vector A and first beat of vector B on consecutive cycles, out_ready=1 -> two results in consecutive cycles; B excludes any A term.

Source files
------------

// File: rtl/fracnet_acc_requant_if.sv
// Handshake bundle between the multiplier pipeline, the accumulator/requantiser and
// its downstream consumer.
interface fracnet_acc_requant_if #(
  parameter int IN_W    = 28,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 5
);
  logic                      in_valid;
  logic                      in_last;
  logic signed [IN_W-1:0]    din;
  logic        [SHIFT_W-1:0] shift;
  logic                      in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   dout;
  logic                      sat;
  logic        [15:0]        term_cnt;

  modport master (
    output in_valid, in_last, din, shift, out_ready,
    input  in_ready, out_valid, dout, sat, term_cnt
  );

  modport slave (
    input  in_valid, in_last, din, shift, out_ready,
    output in_ready, out_valid, dout, sat, term_cnt
  );
endinterface

// File: rtl/fracnet_acc_requant.sv
// Accumulates signed products per dot product, then rounds, shifts and saturates the sum
// into a single-slot valid/ready output. Define FRACNET_ACC_RELU_EN to clamp negatives to 0.
module fracnet_acc_requant #(
  parameter int IN_W    = 28,
  parameter int ACC_W   = 40,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 5
) (
  input logic                   clk,
  input logic                   reset,
  fracnet_acc_requant_if.slave  bus
);

  // Two guard bits: one for acc + din, one for the rounding bias.
  localparam int RW = ACC_W + 2;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic        [15:0]      term_cnt_q, term_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] dout_q, dout_d;
  logic                    sat_q, sat_d;

  logic                    in_ready;
  logic                    accept;
  logic signed [ACC_W-1:0] din_ext;
  logic signed [RW-1:0]    sum;
  logic signed [RW-1:0]    bias;
  logic signed [RW-1:0]    rnd;
  logic signed [RW-1:0]    sat_max;
  logic signed [RW-1:0]    sat_min;
  logic signed [OUT_W-1:0] res;
  logic                    res_sat;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign din_ext  = ACC_W'(bus.din);

  always_comb begin
    sum  = RW'(acc_q) + RW'(din_ext);
    bias = '0;
    if (bus.shift != '0) begin
      bias = RW'(1) << (bus.shift - SHIFT_W'(1));
    end
    rnd = (sum + bias) >>> bus.shift;
`ifdef FRACNET_ACC_RELU_EN
    if (rnd[RW-1]) begin
      rnd = '0;
    end
`endif
    sat_max              = '0;
    sat_max[OUT_W-2:0]   = '1;
    sat_min              = '1;
    sat_min[OUT_W-2:0]   = '0;
    res     = rnd[OUT_W-1:0];
    res_sat = 1'b0;
    if (rnd > sat_max) begin
      res     = sat_max[OUT_W-1:0];
      res_sat = 1'b1;
    end else if (rnd < sat_min) begin
      res     = sat_min[OUT_W-1:0];
      res_sat = 1'b1;
    end
  end

  always_comb begin
    acc_d       = acc_q;
    term_cnt_d  = term_cnt_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    sat_d       = sat_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (bus.in_last) begin
        // Clear in the same cycle so the next vector starts without a bubble.
        acc_d       = '0;
        term_cnt_d  = '0;
        out_valid_d = 1'b1;
        dout_d      = res;
        sat_d       = res_sat;
      end else begin
        acc_d      = acc_q + din_ext;
        term_cnt_d = (term_cnt_q == 16'hFFFF) ? term_cnt_q : term_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      term_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      term_cnt_q  <= term_cnt_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.sat       = sat_q;
  assign bus.term_cnt  = term_cnt_q;

endmodule
